// File: rtl/cpu_register_file_mp.sv
// cpu_register_file_mp: parametrised register file with two write lanes, N read ports and a pending scoreboard.
// Optional write-to-read forwarding is enabled by defining CPU_REGFILE_BYPASS_EN.
module cpu_register_file_mp #(
    parameter int DATA_WIDTH           = 8,
    parameter int NUMBER_OF_REGISTERS  = 32,
    parameter int NUMBER_OF_READ_PORTS = 2,
    parameter int ADDR_WIDTH           = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                                       clock_in,
    input  logic                                       reset_n_in,
    input  logic [1:0]                                 write_enable_in,
    input  logic [2*ADDR_WIDTH-1:0]                    write_address_in,
    input  logic [2*DATA_WIDTH-1:0]                    write_data_in,
    input  logic                                       reserve_enable_in,
    input  logic [ADDR_WIDTH-1:0]                      reserve_address_in,
    input  logic [NUMBER_OF_READ_PORTS*ADDR_WIDTH-1:0] read_address_in,
    output logic [NUMBER_OF_READ_PORTS*DATA_WIDTH-1:0] read_data_out,
    output logic [NUMBER_OF_READ_PORTS-1:0]            read_pending_out,
    output logic [ADDR_WIDTH:0]                        pending_count_out
);
    localparam int DW = DATA_WIDTH;
    localparam int NR = NUMBER_OF_REGISTERS;
    localparam int NP = NUMBER_OF_READ_PORTS;
    localparam int AW = ADDR_WIDTH;

    logic [DW-1:0] regs_q [NR];
    logic [DW-1:0] regs_d [NR];
    logic [NR-1:0] pending_q, pending_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_addr [2];
    logic [DW-1:0] wr_data [2];
    logic [1:0]    wr_valid;
    logic [AW-1:0] rd_addr [NP];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wr_addr[k]  = write_address_in[k*AW +: AW];
            wr_data[k]  = write_data_in[k*DW +: DW];
            wr_valid[k] = write_enable_in[k] && (wr_addr[k] != '0);
        end
    end

    // Lane 1 is applied after lane 0 so it wins a same-address collision; a reserve overrides the clear.
    always_comb begin
        pending_d = pending_q;
        count_d   = '0;
        for (int r = 0; r < NR; r++) regs_d[r] = regs_q[r];
        for (int k = 0; k < 2; k++) begin
            if (wr_valid[k]) begin
                regs_d[wr_addr[k]]    = wr_data[k];
                pending_d[wr_addr[k]] = 1'b0;
            end
        end
        if (reserve_enable_in && (reserve_address_in != '0)) pending_d[reserve_address_in] = 1'b1;
        regs_d[0]    = '0;
        pending_d[0] = 1'b0;
        for (int r = 0; r < NR; r++) count_d = count_d + {{AW{1'b0}}, pending_d[r]};
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int r = 0; r < NR; r++) regs_q[r] <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            for (int r = 0; r < NR; r++) regs_q[r] <= regs_d[r];
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        read_data_out    = '0;
        read_pending_out = '0;
        for (int p = 0; p < NP; p++) begin
            rd_addr[p]                    = read_address_in[p*AW +: AW];
            read_data_out[p*DW +: DW]     = regs_q[rd_addr[p]];
            read_pending_out[p]           = pending_q[rd_addr[p]];
`ifdef CPU_REGFILE_BYPASS_EN
            for (int k = 0; k < 2; k++) begin
                if (wr_valid[k] && (wr_addr[k] == rd_addr[p])) begin
                    read_data_out[p*DW +: DW] = wr_data[k];
                    read_pending_out[p]       = reserve_enable_in && (reserve_address_in == rd_addr[p]);
                end
            end
`else
            for (int k = 0; k < 2; k++) begin
                if (wr_valid[k] && (wr_addr[k] == rd_addr[p])) begin
                    read_data_out[p*DW +: DW] = read_data_out[p*DW +: DW];
                end
            end
`endif
        end
    end

    assign pending_count_out = count_q;
endmodule

// File: tb/tb_cpu_register_file_mp.sv
// tb_cpu_register_file_mp: directed bench with an array-level reference model checked every negedge.
module tb_cpu_register_file_mp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  we = '0;
    logic [9:0]  wa = '0;
    logic [15:0] wd = '0;
    logic        re = 1'b0;
    logic [4:0]  ra = '0;
    logic [9:0]  rda = '0;
    logic [15:0] rdd;
    logic [1:0]  rdp;
    logic [5:0]  cnt;

    logic [1:0]  we2 = '0;
    logic [5:0]  wa2 = '0;
    logic [31:0] wd2 = '0;
    logic        re2 = 1'b0;
    logic [2:0]  ra2 = '0;
    logic [11:0] rda2 = '0;
    logic [63:0] rdd2;
    logic [3:0]  rdp2;
    logic [3:0]  cnt2;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [32];
    bit         pend [32];

    cpu_register_file_mp dut (
        .clock_in(clk), .reset_n_in(rst_n), .write_enable_in(we), .write_address_in(wa),
        .write_data_in(wd), .reserve_enable_in(re), .reserve_address_in(ra),
        .read_address_in(rda), .read_data_out(rdd), .read_pending_out(rdp), .pending_count_out(cnt)
    );

    cpu_register_file_mp #(.DATA_WIDTH(16), .NUMBER_OF_REGISTERS(8), .NUMBER_OF_READ_PORTS(4)) dut4 (
        .clock_in(clk), .reset_n_in(rst_n), .write_enable_in(we2), .write_address_in(wa2),
        .write_data_in(wd2), .reserve_enable_in(re2), .reserve_address_in(ra2),
        .read_address_in(rda2), .read_data_out(rdd2), .read_pending_out(rdp2), .pending_count_out(cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: apply lane 0, then lane 1, then the reserve.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin mem[i] = 8'h00; pend[i] = 1'b0; end
        end else begin
            for (int k = 0; k < 2; k++)
                if (we[k] && wa[k*5 +: 5] != 0) begin
                    mem[wa[k*5 +: 5]]  = wd[k*8 +: 8];
                    pend[wa[k*5 +: 5]] = 1'b0;
                end
            if (re && ra != 0) pend[ra] = 1'b1;
        end
    end

    always @(negedge clk) begin
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(pend[i]);
        for (int p = 0; p < 2; p++) begin
            logic [4:0] a;
            logic [7:0] ed;
            logic       ep;
            a  = rda[p*5 +: 5];
            ed = mem[a];
            ep = pend[a];
`ifdef CPU_REGFILE_BYPASS_EN
            for (int k = 0; k < 2; k++)
                if (we[k] && wa[k*5 +: 5] != 0 && wa[k*5 +: 5] == a) begin
                    ed = wd[k*8 +: 8];
                    ep = re && ra == a;
                end
`endif
            chk($sformatf("model_data_p%0d", p), 32'(rdd[p*8 +: 8]), 32'(ed));
            chk($sformatf("model_pend_p%0d", p), 32'(rdp[p]), 32'(ep));
        end
        chk("model_count", 32'(cnt), 32'(n));
    end

    initial begin
        repeat (2) step();
        chk("reset_count", 32'(cnt), 0);
        rst_n = 1'b1;
        // r5 = 0x3C with a same-edge reserve, then async reset mid-cycle
        we = 2'b01; wa = {5'd0, 5'd5}; wd = 16'h003C; re = 1'b1; ra = 5'd5;
        step();
        we = '0; re = 1'b0; rda = {5'd0, 5'd5};
        #1;
        chk("r5_write", 32'(rdd[7:0]), 32'h3C);
        chk("r5_pend", 32'(rdp[0]), 1);
        chk("r5_count", 32'(cnt), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_data", 32'(rdd[7:0]), 0);
        chk("async_rst_count", 32'(cnt), 0);
        step();
        rst_n = 1'b1;
        // dual write to different registers
        we = 2'b11; wa = {5'd7, 5'd3}; wd = 16'h7F11;
        step();
        we = '0; rda = {5'd7, 5'd3};
        #2;
        chk("dual_r3", 32'(rdd[7:0]), 32'h11);
        chk("dual_r7", 32'(rdd[15:8]), 32'h7F);
        // same-address collision: lane 1 wins
        we = 2'b11; wa = {5'd9, 5'd9}; wd = 16'hF001;
        step();
        we = '0; rda = {5'd0, 5'd9};
        #2;
        chk("collide_r9", 32'(rdd[7:0]), 32'hF0);
        chk("r9_signed", ($signed(rdd[7:0]) == -8'sd16) ? 32'd1 : 32'd0, 1);
        // register 0 ignores writes and reserves
        we = 2'b01; wa = {5'd0, 5'd0}; wd = 16'h0055; re = 1'b1; ra = 5'd0;
        step();
        we = '0; re = 1'b0; rda = {5'd0, 5'd0};
        #2;
        chk("r0_data", 32'(rdd[7:0]), 0);
        chk("r0_pend", 32'(rdp[0]), 0);
        chk("r0_count", 32'(cnt), 0);
        // scoreboard sequence
        re = 1'b1; ra = 5'd4; step(); #1 chk("res_r4_count", 32'(cnt), 1);
        ra = 5'd6; step(); #1 chk("res_r6_count", 32'(cnt), 2);
        ra = 5'd4; step(); #1 chk("res_r4_again_count", 32'(cnt), 2);
        re = 1'b0; we = 2'b10; wa = {5'd4, 5'd0}; wd = 16'h4400;
        step();
        we = '0; rda = {5'd0, 5'd4};
        #2;
        chk("clr_r4_count", 32'(cnt), 1);
        chk("clr_r4_pend", 32'(rdp[0]), 0);
        chk("clr_r4_data", 32'(rdd[7:0]), 32'h44);
        we = 2'b01; wa = {5'd0, 5'd6}; wd = 16'h0066; re = 1'b1; ra = 5'd6;
        step();
        we = '0; re = 1'b0; rda = {5'd0, 5'd6};
        #2;
        chk("resw_r6_pend", 32'(rdp[0]), 1);
        chk("resw_r6_data", 32'(rdd[7:0]), 32'h66);
        chk("resw_r6_count", 32'(cnt), 1);
        // forwarding behaviour on read port 1
        we = 2'b01; wa = {5'd0, 5'd2}; wd = 16'h005A;
        step();
        rda = {5'd2, 5'd0}; wd = 16'h00A5;
        #2;
`ifdef CPU_REGFILE_BYPASS_EN
        chk("bypass_same_cycle", 32'(rdd[15:8]), 32'hA5);
`else
        chk("nobypass_same_cycle", 32'(rdd[15:8]), 32'h5A);
`endif
        step();
        we = '0;
        #2;
        chk("bypass_next_cycle", 32'(rdd[15:8]), 32'hA5);
        // mixed traffic checked by the model only
        for (int i = 0; i < 60; i++) begin
            we = 2'($urandom); wa = 10'($urandom); wd = 16'($urandom);
            re = 1'($urandom); ra = 5'($urandom); rda = 10'($urandom);
            step();
        end
        we = '0; re = 1'b0;
        // wide configuration: four concurrent reads, most negative value preserved
        we2 = 2'b11; wa2 = {3'd2, 3'd1}; wd2 = {16'h7FFF, 16'h8000};
        step();
        wa2 = {3'd4, 3'd3}; wd2 = {16'hFFFF, 16'h1234};
        step();
        we2 = '0; rda2 = {3'd4, 3'd3, 3'd2, 3'd1};
        #2;
        chk("w16_r1", 32'(rdd2[15:0]), 32'h8000);
        chk("w16_r2", 32'(rdd2[31:16]), 32'h7FFF);
        chk("w16_r3", 32'(rdd2[47:32]), 32'h1234);
        chk("w16_r4", 32'(rdd2[63:48]), 32'hFFFF);
        chk("w16_r1_signed", ($signed(rdd2[15:0]) == -16'sd32768) ? 32'd1 : 32'd0, 1);
        chk("w16_count", 32'(cnt2), 0);
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
